// File: rtl/mips_mem_responder.sv
// Memory-side responder for the multi-cycle MIPS core's unified instr/data port.
// It takes one request at a time. After WAIT_CYCLES wait states it answers with a
// one-cycle rsp_valid pulse. It holds a word-addressed RAM plus a "tohost"
// mailbox word that is not backed by RAM.
//
// Handshake: a request is accepted on a rising edge where req_valid && req_ready.
// we_mem/addr_mem/write_data are sampled only on that edge. req_ready is high
// only in IDLE (and never while reset is asserted). rsp_valid, data_mem, addr_err
// and mbox_valid are registered and hold their values for the single RESP cycle.
// Outside RESP, data_mem reads 0.
module mips_mem_responder #(
   parameter int unsigned DEPTH_WORDS  = 64,
   parameter int unsigned WAIT_CYCLES  = 2,
   parameter logic [31:0] MAILBOX_ADDR = 32'h54,
   parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        we_mem,
   input  logic [31:0] addr_mem,
   input  logic [31:0] write_data,
   output logic        rsp_valid,
   output logic [31:0] data_mem,
   output logic        mbox_valid,
   output logic [31:0] mbox_data,
   output logic        addr_err,
   output logic [1:0]  dbg_state
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] data_q, data_d;
   logic        mbox_valid_q, mbox_valid_d;
   logic [31:0] mbox_data_q, mbox_data_d;
   logic        addr_err_q, addr_err_d;

   logic [31:0] mem_q [DEPTH_WORDS];

   logic             accept;
   logic             eff_we;
   logic [31:0]      eff_addr;
   logic [31:0]      eff_wdata;
   logic             misaligned;
   logic             out_range;
   logic             is_mbox;
   logic             acc_err;
   logic [IDX_W-1:0] idx;
   logic             enter_resp;
   logic             mem_we;

   assign req_ready = (state_q == ST_IDLE) && rst;
   assign accept    = req_valid && req_ready;

   // With zero wait states the access executes on the accept edge itself.
   // In that case the decode has to see the live inputs, not the latches.
   assign eff_we    = (state_q == ST_IDLE) ? we_mem     : we_q;
   assign eff_addr  = (state_q == ST_IDLE) ? addr_mem   : addr_q;
   assign eff_wdata = (state_q == ST_IDLE) ? write_data : wdata_q;

   assign misaligned = (eff_addr[1:0] != 2'b00);
   assign is_mbox    = (eff_addr == MAILBOX_ADDR);
   assign out_range  = (eff_addr[31:2] >= 30'(DEPTH_WORDS));
   assign acc_err    = misaligned || (!is_mbox && out_range);
   assign idx        = eff_addr[2 +: IDX_W];

   // Next-state, request latching and access decode for the edge entering RESP
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rsp_valid_d  = 1'b0;
      data_d       = 32'h0;
      mbox_valid_d = 1'b0;
      mbox_data_d  = mbox_data_q;
      addr_err_d   = 1'b0;
      mem_we       = 1'b0;
      enter_resp   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               we_d    = we_mem;
               addr_d  = addr_mem;
               wdata_d = write_data;
               if (WAIT_CYCLES == 0) begin
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(WAIT_CYCLES);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q <= 4'd1) begin
               state_d = ST_RESP;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

      if (enter_resp) begin
         rsp_valid_d = 1'b1;
         if (acc_err) begin
            addr_err_d = 1'b1;
            if (!eff_we) begin
               data_d = ERR_DATA;
            end
         end else if (is_mbox) begin
            if (eff_we) begin
               mbox_data_d  = eff_wdata;
               mbox_valid_d = 1'b1;
            end else begin
               data_d = mbox_data_q;
            end
         end else begin
            if (eff_we) begin
               mem_we = 1'b1;
            end else begin
               data_d = mem_q[idx];
            end
         end
      end
   end

   // Control state and registered response outputs; reset drops any pending request
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 4'd0;
         we_q         <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         rsp_valid_q  <= 1'b0;
         data_q       <= 32'h0;
         mbox_valid_q <= 1'b0;
         mbox_data_q  <= 32'h0;
         addr_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         rsp_valid_q  <= rsp_valid_d;
         data_q       <= data_d;
         mbox_valid_q <= mbox_valid_d;
         mbox_data_q  <= mbox_data_d;
         addr_err_q   <= addr_err_d;
      end
   end

   // RAM write port; contents survive reset, and the write is blocked while reset is held
   always_ff @(posedge clk) begin
      if (mem_we && rst) begin
         mem_q[idx] <= eff_wdata;
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign data_mem   = data_q;
   assign mbox_valid = mbox_valid_q;
   assign mbox_data  = mbox_data_q;
   assign addr_err   = addr_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Bench for mips_mem_responder.
// Main instance: WAIT_CYCLES=2.
// Second instance: WAIT_CYCLES=0, which checks the zero-wait path.
module tb_mips_mem_responder;

   localparam int TB_WAIT = 2;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- main DUT ----------------
   logic        req_valid, req_ready, we_mem, rsp_valid, mbox_valid, addr_err;
   logic [31:0] addr_mem, write_data, data_mem, mbox_data;
   logic [1:0]  dbg_state;

   mips_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(TB_WAIT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .we_mem(we_mem), .addr_mem(addr_mem), .write_data(write_data),
      .rsp_valid(rsp_valid), .data_mem(data_mem), .mbox_valid(mbox_valid),
      .mbox_data(mbox_data), .addr_err(addr_err), .dbg_state(dbg_state)
   );

   // ---------------- zero-wait DUT ----------------
   logic        req_valid0, req_ready0, we_mem0, rsp_valid0, mbox_valid0, addr_err0;
   logic [31:0] addr_mem0, write_data0, data_mem0, mbox_data0;
   logic [1:0]  dbg_state0;

   mips_mem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(req_valid0), .req_ready(req_ready0),
      .we_mem(we_mem0), .addr_mem(addr_mem0), .write_data(write_data0),
      .rsp_valid(rsp_valid0), .data_mem(data_mem0), .mbox_valid(mbox_valid0),
      .mbox_data(mbox_data0), .addr_err(addr_err0), .dbg_state(dbg_state0)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_errors = 0;
   // entry: {data[31:0], mbox_data[31:0], addr_err, mbox_valid}
   logic [65:0] exp_q[$];
   logic [31:0] ref_mem [64];
   logic [31:0] mbox_ref = 32'h0;

   int cyc = 0;
   int acc_cyc = 0;
   int acc_count = 0;
   bit acc_valid = 1'b0;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_data;
      logic [31:0] exp_mbd;
      logic        exp_err;
      logic        exp_mb;
   } vec_t;
   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Cycle count and accept tracking, used for latency and ready checks
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         acc_valid <= 1'b0;
      end else if (req_valid && req_ready) begin
         acc_valid <= 1'b1;
         acc_cyc   <= cyc;
         acc_count <= acc_count + 1;
      end
   end

   // Monitor: check every cycle, and pop the expected queue on each response
   always @(negedge clk) begin
      logic [65:0] e;
      logic        exp_ready;
      exp_ready = rst && !(acc_valid && ((cyc - acc_cyc) <= TB_WAIT + 1));
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      if (!rsp_valid) begin
         chk("idle_data_zero", data_mem, 32'h0);
         chk("pulse_outside_rsp", 32'({mbox_valid, addr_err}), 32'h0);
      end else if (exp_q.size() == 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (t=%0t)", $time);
      end else begin
         e = exp_q.pop_front();
         chk("rsp_data", data_mem, e[65:34]);
         chk("rsp_mbox_data", mbox_data, e[33:2]);
         chk("rsp_addr_err", 32'(addr_err), 32'(e[1]));
         chk("rsp_mbox_valid", 32'(mbox_valid), 32'(e[0]));
         chk("rsp_latency", 32'(cyc - acc_cyc), 32'(TB_WAIT + 1));
      end
   end

   // ---------------- driver tasks (entered at posedge+2) ----------------
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [65:0] e, input bit hold);
      int n0;
      bit got;
      n0 = acc_count;
      got = 1'b0;
      req_valid = 1'b1; we_mem = we; addr_mem = addr; write_data = wd;
      for (int i = 0; i < 20 && !got; i++) begin
         @(posedge clk); #2;
         if (acc_count != n0) got = 1'b1;
      end
      if (got) begin
         exp_q.push_back(e);
      end else begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got no accept expected accept within 20 cycles addr=%h", addr);
      end
      if (!hold) begin
         req_valid = 1'b0;
         we_mem = 1'($urandom);
         addr_mem = $urandom;
         write_data = $urandom;
      end
   endtask

   task automatic model_req(input logic we, input logic [31:0] addr, input logic [31:0] wd, input bit hold);
      logic [31:0] d;
      logic err, mb;
      d = 32'h0; err = 1'b0; mb = 1'b0;
      if (addr[1:0] != 2'b00 || (addr != 32'h54 && addr >= 32'h100)) begin
         err = 1'b1;
         if (!we) d = 32'hDEADBEEF;
      end else if (addr == 32'h54) begin
         if (we) begin mbox_ref = wd; mb = 1'b1; end
         else d = mbox_ref;
      end else begin
         if (we) ref_mem[addr[7:2]] = wd;
         else d = ref_mem[addr[7:2]];
      end
      do_req(we, addr, wd, {d, mbox_ref, err, mb}, hold);
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
         @(posedge clk); #2;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic w0_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_mb, input logic [31:0] exp_mbd);
      req_valid0 = 1'b1; we_mem0 = we; addr_mem0 = addr; write_data0 = wd;
      @(negedge clk);
      chk("w0_ready_before", 32'(req_ready0), 32'h1);
      @(posedge clk); #2;
      req_valid0 = 1'b0; addr_mem0 = $urandom; write_data0 = $urandom;
      @(negedge clk);
      chk("w0_rsp_valid", 32'(rsp_valid0), 32'h1);
      chk("w0_data", data_mem0, exp_d);
      chk("w0_mbox_valid", 32'(mbox_valid0), 32'(exp_mb));
      chk("w0_mbox_data", mbox_data0, exp_mbd);
      chk("w0_addr_err", 32'(addr_err0), 32'h0);
      chk("w0_state_resp", 32'(dbg_state0), 32'h2);
      @(negedge clk);
      chk("w0_rsp_gone", 32'(rsp_valid0), 32'h0);
      chk("w0_ready_after", 32'(req_ready0), 32'h1);
      chk("w0_data_zero", data_mem0, 32'h0);
      @(posedge clk); #2;
   endtask

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   // ---------------- main sequence ----------------
   initial begin
      int first;
      int t[4];
      logic [31:0] old2;

      vecs[0]  = '{1'b1, 32'h10,  32'h12345678, 32'h0,        32'h0, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 32'h10,  32'h0,        32'h12345678, 32'h0, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, 32'h54,  32'h7,        32'h0,        32'h7, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 32'h54,  32'h0,        32'h7,        32'h7, 1'b0, 1'b0};
      vecs[4]  = '{1'b0, 32'h52,  32'h0,        32'hDEADBEEF, 32'h7, 1'b1, 1'b0};
      vecs[5]  = '{1'b0, 32'h400, 32'h0,        32'hDEADBEEF, 32'h7, 1'b1, 1'b0};
      vecs[6]  = '{1'b1, 32'h401, 32'h11111111, 32'h0,        32'h7, 1'b1, 1'b0};
      vecs[7]  = '{1'b1, 32'hFC,  32'hA5A50001, 32'h0,        32'h7, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 32'hFC,  32'h0,        32'hA5A50001, 32'h7, 1'b0, 1'b0};
      vecs[9]  = '{1'b0, 32'h100, 32'h0,        32'hDEADBEEF, 32'h7, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 32'h56,  32'h99,       32'h0,        32'h7, 1'b1, 1'b0};
      vecs[11] = '{1'b0, 32'h54,  32'h0,        32'h7,        32'h7, 1'b0, 1'b0};
      vecs[12] = '{1'b1, 32'h10,  32'hCAFEF00D, 32'h0,        32'h7, 1'b0, 1'b0};
      vecs[13] = '{1'b0, 32'h10,  32'h0,        32'hCAFEF00D, 32'h7, 1'b0, 1'b0};
      vecs[14] = '{1'b1, 32'h0,   32'h1,        32'h0,        32'h7, 1'b0, 1'b0};
      vecs[15] = '{1'b0, 32'h0,   32'h0,        32'h1,        32'h7, 1'b0, 1'b0};

      req_valid = 1'b0; we_mem = 1'b0; addr_mem = 32'h0; write_data = 32'h0;
      req_valid0 = 1'b0; we_mem0 = 1'b0; addr_mem0 = 32'h0; write_data0 = 32'h0;
      rst = 1'b1;
      #1 rst = 1'b0;

      // Reset held for 3 cycles: all outputs quiet
      repeat (3) begin
         @(negedge clk);
         chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
         chk("rst_data", data_mem, 32'h0);
         chk("rst_mbox_valid", 32'(mbox_valid), 32'h0);
         chk("rst_mbox_data", mbox_data, 32'h0);
         chk("rst_addr_err", 32'(addr_err), 32'h0);
         chk("rst_ready", 32'(req_ready), 32'h0);
      end
      @(posedge clk); #2;
      rst = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", 32'(req_ready), 32'h1);
      chk("post_rst_state", 32'(dbg_state), 32'h0);
      chk("post_rst_mbox_data", mbox_data, 32'h0);
      @(posedge clk); #2;

      // Table-driven vectors
      for (int i = 0; i < 16; i++) begin
         do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata,
                {vecs[i].exp_data, vecs[i].exp_mbd, vecs[i].exp_err, vecs[i].exp_mb}, 1'b0);
      end
      drain();
      mbox_ref = 32'h7;

      // Fill every RAM word except 21, which is shadowed by the mailbox
      for (int i = 0; i < 64; i++) begin
         if (i != 21) model_req(1'b1, 32'(i * 4), $urandom, 1'b0);
      end
      // Erroneous writes must not touch RAM or the mailbox
      model_req(1'b1, 32'h401, 32'hBAD0BAD0, 1'b0);
      model_req(1'b1, 32'h400, 32'hBAD1BAD1, 1'b0);
      model_req(1'b1, 32'h100, 32'hBAD2BAD2, 1'b0);
      model_req(1'b1, 32'h56,  32'hBAD3BAD3, 1'b0);
      model_req(1'b1, 32'h2,   32'hBAD4BAD4, 1'b0);
      for (int i = 0; i < 64; i++) begin
         if (i != 21) model_req(1'b0, 32'(i * 4), 32'h0, 1'b0);
      end
      model_req(1'b0, 32'h54, 32'h0, 1'b0);
      drain();

      // Back-to-back: req_valid held high across 4 requests
      first = acc_count;
      model_req(1'b1, 32'h14, $urandom, 1'b1); t[0] = acc_cyc;
      model_req(1'b1, 32'h18, $urandom, 1'b1); t[1] = acc_cyc;
      model_req(1'b0, 32'h14, 32'h0, 1'b1);    t[2] = acc_cyc;
      model_req(1'b0, 32'h18, 32'h0, 1'b0);    t[3] = acc_cyc;
      for (int i = 0; i < 3; i++) begin
         chk("b2b_spacing", 32'(t[i+1] - t[i]), 32'(TB_WAIT + 2));
      end
      repeat (8) begin @(posedge clk); #2; end
      chk("b2b_accept_count", 32'(acc_count - first), 32'h4);
      drain();

      // Reset during WAIT of a write to word 2
      old2 = ref_mem[2];
      do_req(1'b1, 32'h8, ~old2, {32'h0, mbox_ref, 1'b0, 1'b0}, 1'b0);
      @(posedge clk); #2;
      rst = 1'b0;
      exp_q.delete();
      mbox_ref = 32'h0;
      repeat (2) begin @(posedge clk); end
      #2 rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ready", 32'(req_ready), 32'h1);
      chk("mid_rst_state", 32'(dbg_state), 32'h0);
      chk("mid_rst_mbox_data", mbox_data, 32'h0);
      @(posedge clk); #2;
      model_req(1'b0, 32'h8, 32'h0, 1'b0);
      model_req(1'b0, 32'h54, 32'h0, 1'b0);
      model_req(1'b0, 32'h0C, 32'h0, 1'b0);
      drain();

      // Zero-wait build: response one cycle after accept
      w0_req(1'b1, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, 32'h0);
      w0_req(1'b0, 32'h20, 32'h0,        32'h0BADF00D, 1'b0, 32'h0);
      w0_req(1'b1, 32'h54, 32'h9,        32'h0, 1'b1, 32'h9);
      w0_req(1'b0, 32'h54, 32'h0,        32'h9, 1'b0, 32'h9);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
